// File: rtl/wide_add_pkg.sv
// ---------------------------------------------------------------------------
// wide_add_pkg
// Shared definitions for the multi-precision add sequencer:
//   - state_t          : sequencer FSM states (IDLE, RUN, DONE)
//   - DEFAULT_*        : default slice geometry (8-bit slice, 4 slices)
//   - idxWidth()       : width of the slice index counter, never below 1
// ---------------------------------------------------------------------------
package wide_add_pkg;

    localparam int DEFAULT_SLICE_WIDTH = 8;
    localparam int DEFAULT_NUM_SLICES  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-slice configuration still needs a 1-bit counter so the
    // index register never collapses to zero width.
    function automatic int idxWidth(input int numSlices);
        return (numSlices > 1) ? $clog2(numSlices) : 1;
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// ---------------------------------------------------------------------------
// adder_nbit
// Plain ripple-carry adder slice, purely combinational.
// Ports:
//   a, b      in  BIT_WIDTH  addends
//   carry_in  in  1          carry into bit 0
//   sum       out BIT_WIDTH  a + b + carry_in, modulo 2^BIT_WIDTH
//   overflow  out 1          carry out of the top bit
// ---------------------------------------------------------------------------
module adder_nbit #(
    parameter int BIT_WIDTH = 8
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    logic [BIT_WIDTH:0] w_carry;

    assign w_carry[0] = carry_in;

    // One full adder per bit; the carry chain is the slice's critical path.
    for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign overflow = w_carry[BIT_WIDTH];

endmodule

// File: rtl/wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer
// Computes a NUM_SLICES*SLICE_WIDTH-bit sum by feeding one shared
// SLICE_WIDTH-bit adder slice, least significant slice first, carrying the
// slice overflow forward in a register between cycles.
// Ports:
//   i_clk        in  1  clock, rising edge
//   i_rst        in  1  synchronous active-high reset
//   i_start      in  1  request, taken only while o_ready is high
//   i_op_a       in  W  operand A, captured on the accepted start
//   i_op_b       in  W  operand B, captured on the accepted start
//   i_carry_in   in  1  initial carry, captured on the accepted start
//   o_ready      out 1  idle and able to accept a request
//   o_busy       out 1  an operation is in flight (RUN or DONE)
//   o_done       out 1  single-cycle pulse, result/carry valid this cycle
//   o_result     out W  registered sum, updated only entering DONE
//   o_carry_out  out 1  registered carry out of bit W-1
// ---------------------------------------------------------------------------
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int SLICE_WIDTH = DEFAULT_SLICE_WIDTH,
    parameter int NUM_SLICES  = DEFAULT_NUM_SLICES
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic [SLICE_WIDTH*NUM_SLICES-1:0] i_op_a,
    input  logic [SLICE_WIDTH*NUM_SLICES-1:0] i_op_b,
    input  logic                              i_carry_in,
    output logic                              o_ready,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [SLICE_WIDTH*NUM_SLICES-1:0] o_result,
    output logic                              o_carry_out
);

    localparam int W     = SLICE_WIDTH * NUM_SLICES;
    localparam int IDX_W = idxWidth(NUM_SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_t                 r_state;
    state_t                 w_nextState;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_carry;
    logic [W-1:0]           r_shiftA;
    logic [W-1:0]           r_shiftB;
    logic [W-1:0]           r_shiftSum;
    logic [W-1:0]           r_result;
    logic                   r_carryOut;

    logic [SLICE_WIDTH-1:0] w_sliceSum;
    logic                   w_sliceOverflow;
    logic [W+SLICE_WIDTH-1:0] w_sumCat;
    logic [W-1:0]           w_sumNext;
    logic                   w_lastSlice;

    // The single shared slice always looks at the bottom slice of the
    // operand shift registers; the FSM decides when its output is used.
    adder_nbit #(
        .BIT_WIDTH (SLICE_WIDTH)
    ) u_adder (
        .a        (r_shiftA[SLICE_WIDTH-1:0]),
        .b        (r_shiftB[SLICE_WIDTH-1:0]),
        .carry_in (r_carry),
        .sum      (w_sliceSum),
        .overflow (w_sliceOverflow)
    );

    // New slice sums enter at the top and everything moves down one slice,
    // so after NUM_SLICES steps slice 0 sits at the bottom. Concatenating
    // before the shift keeps this valid when there is only one slice.
    assign w_sumCat    = {w_sliceSum, r_shiftSum} >> SLICE_WIDTH;
    assign w_sumNext   = w_sumCat[W-1:0];
    assign w_lastSlice = (r_idx == LAST_IDX);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs. DONE always returns to IDLE, so any
    // start seen while busy is simply dropped.
    always_comb begin
        w_nextState = r_state;
        o_ready     = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                if (w_lastSlice) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on an accepted start, then step one slice
    // per RUN cycle. The output registers load from the same-edge shifted
    // sum so they are already valid in the DONE cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_shiftA   <= '0;
            r_shiftB   <= '0;
            r_shiftSum <= '0;
            r_result   <= '0;
            r_carryOut <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_shiftA <= i_op_a;
                        r_shiftB <= i_op_b;
                        r_carry  <= i_carry_in;
                        r_idx    <= '0;
                    end
                end
                RUN: begin
                    r_shiftA   <= r_shiftA >> SLICE_WIDTH;
                    r_shiftB   <= r_shiftB >> SLICE_WIDTH;
                    r_shiftSum <= w_sumNext;
                    r_carry    <= w_sliceOverflow;
                    r_idx      <= r_idx + 1'b1;
                    if (w_lastSlice) begin
                        r_result   <= w_sumNext;
                        r_carryOut <= w_sliceOverflow;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result    = r_result;
    assign o_carry_out = r_carryOut;

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-precision add controller. It computes a NUM_SLICES×SLICE_WIDTH-bit sum by time-multiplexing one SLICE_WIDTH-bit ripple-carry adder slice (`adder_nbit`) across operand slices, least significant slice first. The carry is registered between cycles. The block sits between a requester using a start/ready/done handshake and the single shared adder instance, so a wide add costs one narrow adder plus control.

## Interface
- SLICE_WIDTH, 8, width of the shared adder slice in bits
- NUM_SLICES, 4, number of slices per operation (≥1); total width W = SLICE_WIDTH×NUM_SLICES
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- op_a  in  W  operand A, sampled on the accepted start cycle
- op_b  in  W  operand B, sampled on the accepted start cycle
- carry_in  in  1  initial carry, sampled on the accepted start cycle
- ready  out  1  high in IDLE only
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result and carry_out are valid on this cycle
- result  out  W  registered sum; changes only on the done cycle
- carry_out  out  1  registered final carry; changes only on the done cycle

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1, latch op_a and op_b into shift registers, set carry_q=carry_in, set idx=0, and go to RUN. start=0 stays in IDLE.
- RUN: the adder slice receives the low SLICE_WIDTH bits of the A and B shift registers, with carry_q as its carry input.
  - Each cycle the slice sum is shifted into the top of the sum shift register.
  - carry_q takes the slice overflow (carry out).
  - The A and B registers shift right by SLICE_WIDTH, and idx increments.
  - When idx==NUM_SLICES-1, go to DONE.
- DONE: done=1. result is loaded from the sum shift register and carry_out from carry_q, on the edge entering DONE, so both are valid during the done cycle. Next state is IDLE unconditionally.
- start is ignored while busy. Operands are not re-sampled and no error is flagged.
- Arithmetic is unsigned modulo 2^W. carry_out is the carry out of bit W-1. Signed overflow is not reported.
- NUM_SLICES=1: RUN lasts exactly one cycle.
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, carry_out=0, idx=0, carry_q=0, all shift registers 0.
- Reset asserted mid-operation: the operation is abandoned with no done pulse, and result keeps its reset value of 0.

## Timing
- start accepted at edge 0; RUN occupies cycles 1..NUM_SLICES; done is high in cycle NUM_SLICES+1.
- Total latency from accepted start to done is NUM_SLICES+1 cycles (5 at the defaults).
- ready returns high the cycle after done, so back-to-back throughput is one operation per NUM_SLICES+2 cycles.
- result and carry_out hold stable from the done cycle until the next done or reset.
- The adder slice path is purely combinational within one cycle. The critical path is the SLICE_WIDTH ripple plus shift-register setup.
- idx width is $clog2(NUM_SLICES), minimum 1.

## Structure
- Shared package wide_add_pkg: state enum (IDLE, RUN, DONE) and default SLICE_WIDTH/NUM_SLICES localparams.
- One sub-module: `adder_nbit` instantiated once with #(.BIT_WIDTH(SLICE_WIDTH)), ports a, b, carry_in, sum, overflow.
- The sequencer holds:
  - the FSM;
  - the idx counter;
  - carry_q;
  - the A/B/sum shift registers;
  - the output registers.

## Test plan
- Defaults, op_a=0x0000_00FF, op_b=0x0000_0001, carry_in=0 → done exactly 5 cycles after start; result=0x0000_0100, carry_out=0.
- op_a=0xFFFF_FFFF, op_b=0x0000_0000, carry_in=1 → result=0x0000_0000, carry_out=1. The carry must ripple through all 4 slices.
- Pulse start=1 on every cycle:
  - starts are accepted only when ready=1, exactly every 6 cycles;
  - the start pulse on the done cycle is ignored;
  - an operand change during RUN has no effect on the result.
- Assert rst during the 2nd RUN cycle of 0x1234_5678+0x1111_1111 → next cycle state=IDLE, ready=1, no done pulse, result=0. A following add of 0x1234_5678+0x1111_1111 gives 0x2345_6789.
- NUM_SLICES=1, SLICE_WIDTH=8, op_a=0x80, op_b=0x80, carry_in=0 → done 2 cycles after start; result=0x00, carry_out=1.
- 1000 random operand/carry_in triples at the defaults → every result and carry_out equals the reference {carry_out, result} = op_a+op_b+carry_in, and every latency is 5.
